// File: rtl/intr_ctrl.sv
// intr_ctrl: round-robin interrupt scheduler with rising-edge latching, per-source mask and ack timeout
//   clk       system clock
//   rst       synchronous reset, active-high
//   int_i     raw level interrupt sources (INT_NUM)
//   mask_i    per-source service enable (INT_NUM)
//   ack_i     CPU acknowledge pulse, honoured only while int_o=1
//   int_o     registered interrupt request to CPU
//   int_id_o  ID of the served source, held while int_o=1 and kept afterwards
//   pending_o latched pending sources (INT_NUM)
module intr_ctrl #(
    parameter int INT_NUM     = 32,
    parameter int ID_W        = 5,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_i,
    input  logic [INT_NUM-1:0] mask_i,
    input  logic               ack_i,
    output logic               int_o,
    output logic [ID_W-1:0]    int_id_o,
    output logic [INT_NUM-1:0] pending_o
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(INT_NUM - 1);
    localparam logic [15:0]     TO_LAST = 16'(ACK_TIMEOUT - 1);
    state_t             state, state_n;
    logic [INT_NUM-1:0] int_d, elig, clr, pending_n;
    logic [ID_W-1:0]    ptr, ptr_n, win, win_hi, win_any, id_n;
    logic [15:0]        cnt, cnt_n;
    logic               found_hi, int_n;
    assign elig = pending_o & mask_i;
    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        win_hi   = '0;
        win_any  = '0;
        found_hi = 1'b0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (elig[i] && ID_W'(i) >= ptr) begin
                win_hi   = ID_W'(i);
                found_hi = 1'b1;
            end
            if (elig[i]) win_any = ID_W'(i);
        end
        win = found_hi ? win_hi : win_any;
    end
    always_comb begin
        state_n = state;
        int_n   = int_o;
        id_n    = int_id_o;
        ptr_n   = ptr;
        cnt_n   = cnt;
        clr     = '0;
        case (state)
            IDLE: if (|elig) begin
                id_n    = win;
                int_n   = 1'b1;
                cnt_n   = '0;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: if (ack_i) begin
                clr[int_id_o] = 1'b1;
                int_n         = 1'b0;
                ptr_n         = (int_id_o == LAST_ID) ? '0 : int_id_o + 1'b1;
                state_n       = GAP;
            end else if (ACK_TIMEOUT != 0 && cnt == TO_LAST) begin
                int_n   = 1'b0;
                state_n = GAP;
            end else begin
                cnt_n = cnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
        // A fresh edge in the ack cycle overrides the clear.
        pending_n = (pending_o & ~clr) | (int_i & ~int_d);
    end
    // int_d keeps sampling through reset so a source held high across reset does not re-trigger.
    always_ff @(posedge clk) begin
        int_d <= int_i;
        if (rst) begin
            state     <= IDLE;
            int_o     <= 1'b0;
            int_id_o  <= '0;
            pending_o <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            int_o     <= int_n;
            int_id_o  <= id_n;
            pending_o <= pending_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl
module tb_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] int_i, mask_i;
    logic        ack_i;
    logic        int_o;
    logic [4:0]  int_id_o;
    logic [31:0] pending_o;
    int errors = 0;
    int checks = 0;
    intr_ctrl #(.INT_NUM(32), .ID_W(5), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .int_i(int_i), .mask_i(mask_i), .ack_i(ack_i),
        .int_o(int_o), .int_id_o(int_id_o), .pending_o(pending_o)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        int_i = '0;
        ack_i = 1'b0;
        rst   = 1'b1;
        tick(1);
        rst   = 1'b0;
    endtask
    task automatic ack_pulse();
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
    endtask
    initial begin
        rst = 1'b1; int_i = '0; mask_i = '1; ack_i = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_int_o", int_o, 0);
        chk("rst_id", int_id_o, 0);
        chk("rst_pending", pending_o, 0);
        int_i[3] = 1'b1;
        tick(1);
        chk("t1_pend_set", pending_o, 32'h8);
        chk("t1_int_o_early", int_o, 0);
        tick(1);
        chk("t1_int_o", int_o, 1);
        chk("t1_id", int_id_o, 3);
        tick(3);
        chk("t1_hold", int_o, 1);
        ack_pulse();
        chk("t1_ack_int_o", int_o, 0);
        chk("t1_ack_pend", pending_o, 0);
        tick(2);
        chk("t1_idle", int_o, 0);
        do_reset();
        int_i = 32'h8000_0021;
        tick(1);
        int_i = '0;
        chk("t2_pend", pending_o, 32'h8000_0021);
        tick(1);
        chk("t2_id0", int_id_o, 0);
        tick(1);
        ack_pulse();
        chk("t2_pend_a", pending_o, 32'h8000_0020);
        tick(2);
        chk("t2_int_o5", int_o, 1);
        chk("t2_id5", int_id_o, 5);
        tick(1);
        ack_pulse();
        tick(2);
        chk("t2_id31", int_id_o, 31);
        tick(1);
        ack_pulse();
        chk("t2_pend_empty", pending_o, 0);
        int_i = 32'h21;
        tick(1);
        int_i = '0;
        tick(1);
        chk("t2_wrap_id0", int_id_o, 0);
        chk("t2_wrap_int_o", int_o, 1);
        tick(1);
        ack_pulse();
        tick(2);
        chk("t2_wrap_id5", int_id_o, 5);
        ack_pulse();
        do_reset();
        mask_i[7] = 1'b0;
        int_i[7] = 1'b1;
        tick(1);
        int_i[7] = 1'b0;
        tick(3);
        chk("t3_masked_int_o", int_o, 0);
        chk("t3_masked_pend", pending_o, 32'h80);
        mask_i[7] = 1'b1;
        tick(1);
        chk("t3_int_o", int_o, 1);
        chk("t3_id", int_id_o, 7);
        ack_pulse();
        do_reset();
        int_i[2] = 1'b1;
        tick(1);
        int_i[2] = 1'b0;
        tick(1);
        chk("t4_grant", int_o, 1);
        tick(15);
        chk("t4_still_high", int_o, 1);
        tick(1);
        chk("t4_timeout", int_o, 0);
        chk("t4_pend_kept", pending_o, 32'h4);
        tick(1);
        chk("t4_gap", int_o, 0);
        tick(1);
        chk("t4_regrant", int_o, 1);
        chk("t4_regrant_id", int_id_o, 2);
        ack_pulse();
        do_reset();
        int_i[9] = 1'b1;
        tick(2);
        chk("t5_id", int_id_o, 9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_int_o", int_o, 0);
        chk("t5_rst_id", int_id_o, 0);
        chk("t5_rst_pend", pending_o, 0);
        tick(3);
        chk("t5_no_retrigger", pending_o, 0);
        chk("t5_no_int", int_o, 0);
        int_i[9] = 1'b0;
        tick(1);
        int_i[9] = 1'b1;
        tick(1);
        chk("t5_toggle_pend", pending_o, 32'h200);
        tick(1);
        chk("t5_toggle_id", int_id_o, 9);
        ack_pulse();
        do_reset();
        int_i[4] = 1'b1;
        tick(1);
        int_i[4] = 1'b0;
        tick(1);
        chk("t6_id", int_id_o, 4);
        tick(1);
        int_i[4] = 1'b1;
        ack_pulse();
        chk("t6_ack_int_o", int_o, 0);
        chk("t6_pend_stays", pending_o, 32'h10);
        tick(2);
        chk("t6_regrant", int_o, 1);
        chk("t6_regrant_id", int_id_o, 4);
        ack_pulse();
        chk("t6_cleared", pending_o, 0);
        ack_pulse();
        chk("t6_stray_ack_int_o", int_o, 0);
        chk("t6_id_kept", int_id_o, 4);
        tick(2);
        chk("t6_stray_ack_pend", pending_o, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
